// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, issues imem requests under a credit limit, buffers in-order responses and flushes on redirect (IFETCH_MISALIGN_EN halts fetch on a misaligned redirect)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        instr_misaligned
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
  logic [31:0] pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop, count;
  logic [PW-1:0] head, tail;
  logic run, halted, req_fire, rsp_ok, push, pop;
  logic [31:0] fifo_data [BUF_DEPTH];
  logic [31:0] fifo_pc [BUF_DEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction

  assign target = redirect_pc & ~32'h3;
  assign imem_req_valid = run && !redirect_valid && !halted &&
                          ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_ok = imem_rsp_valid && outstanding != '0;
  assign push = rsp_ok && drop == '0 && !redirect_valid;
  assign instr_valid = count != '0;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign instr = instr_valid ? fifo_data[head] : '0;
  assign instr_pc = instr_valid ? fifo_pc[head] : '0;
  assign instr_misaligned = halted;

  // PC, credit and drop bookkeeping plus FIFO pointers; redirect overrides everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      run <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (redirect_valid) begin
        pc <= target;
        rsp_pc <= target;
        drop <= outstanding - CW'(rsp_ok);
        count <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_ok && drop != '0) drop <= drop - 1'b1;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          tail <= nxt(tail);
        end
        if (pop) head <= nxt(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end

  // FIFO storage; kept responses after a redirect belong to consecutive addresses from the target
  always_ff @(posedge clk)
    if (push) begin
      fifo_data[tail] <= imem_rsp_data;
      fifo_pc[tail] <= rsp_pc;
    end

`ifdef IFETCH_MISALIGN_EN
  // a misaligned redirect halts fetch until the next aligned redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) halted <= 1'b0;
    else if (redirect_valid) halted <= redirect_pc[1:0] != 2'b00;
`else
  assign halted = 1'b0;
`endif

  // a response with nothing outstanding is a memory protocol violation
  always_ff @(posedge clk)
    if (rst_n) assert (!(imem_rsp_valid && outstanding == '0));
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: vector table, directed redirect/fill/wrap sequences and randomized traffic against an epoch-tagged memory model
module tb_ifetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef IFETCH_MISALIGN_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic instr_valid, instr_ready, instr_misaligned;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc;

  ifetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .instr_misaligned(instr_misaligned));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] rr, rv, rdata, ir, ev, ea, iv, ipc; } vec_t;

  req_t mq[$];
  logic [31:0] bq[$];
  logic [31:0] got_q[$];
  int epoch, cyc, lat_min = 1, lat_max = 1, checks = 0, errors = 0;
  logic [31:0] next_req;
  logic halted_m, run_m;
  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_got(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (got_q.size() <= idx || got_q[idx] !== exp) begin
      errors++;
      $display("FAIL %s: delivered %0d instrs, entry %0d got %h expected %h", name, got_q.size(), idx,
               got_q.size() > idx ? got_q[idx] : 32'hxxxx_xxxx, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misaligned", 32'(instr_misaligned), 32'h0);
    mq.delete(); bq.delete(); got_q.delete();
    next_req = '0; halted_m = 1'b0; run_m = 1'b0; epoch = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_req_valid", 32'(imem_req_valid), 32'h0);
    run_m = 1'b1;
  endtask

  task automatic step(input logic rr, input logic ir, input logic rd, input logic [31:0] rpc, input logic hold);
    logic exp_rv;
    req_t r;
    @(posedge clk);
    #1;
    imem_req_ready = rr; instr_ready = ir; redirect_valid = rd; redirect_pc = rpc;
    imem_rsp_valid = !hold && mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? mq[0].addr ^ KEY : 32'h0;
    @(negedge clk);
    exp_rv = run_m && !rd && !halted_m && (mq.size() + bq.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, next_req);
    chk("instr_valid", 32'(instr_valid), 32'(bq.size() > 0));
    chk("instr_pc", instr_pc, bq.size() > 0 ? bq[0] : 32'h0);
    chk("instr", instr, bq.size() > 0 ? bq[0] ^ KEY : 32'h0);
    chk("misaligned", 32'(instr_misaligned), 32'(halted_m));
    if (instr_valid && ir && !rd) got_q.push_back(instr_pc);
    if (!rd && ir && bq.size() > 0) void'(bq.pop_front());
    if (imem_rsp_valid) begin
      r = mq.pop_front();
      if (!rd && r.epoch == epoch) bq.push_back(r.addr);
    end
    if (exp_rv && rr) begin
      mq.push_back('{next_req, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
      next_req += 32'd4;
    end
    if (rd) begin
      bq.delete();
      epoch++;
      next_req = rpc & ~32'h3;
      halted_m = MIS && rpc[1:0] != 2'b00;
    end
    cyc++;
  endtask

  initial begin
    tv = '{
      '{32'd0, 32'd0, 32'h0,         32'd1, 32'd1, 32'h0,  32'd0, 32'h0},
      '{32'd0, 32'd0, 32'h0,         32'd1, 32'd1, 32'h0,  32'd0, 32'h0},
      '{32'd0, 32'd0, 32'h0,         32'd1, 32'd1, 32'h0,  32'd0, 32'h0},
      '{32'd1, 32'd0, 32'h0,         32'd1, 32'd1, 32'h0,  32'd0, 32'h0},
      '{32'd1, 32'd1, 32'hA5A50000,  32'd1, 32'd1, 32'h4,  32'd0, 32'h0},
      '{32'd1, 32'd1, 32'hA5A50004,  32'd1, 32'd0, 32'h0,  32'd1, 32'h0},
      '{32'd1, 32'd0, 32'h0,         32'd1, 32'd1, 32'h8,  32'd1, 32'h4},
      '{32'd1, 32'd1, 32'hA5A50008,  32'd1, 32'd1, 32'hC,  32'd0, 32'h0},
      '{32'd0, 32'd1, 32'hA5A5000C,  32'd0, 32'd0, 32'h0,  32'd1, 32'h8},
      '{32'd0, 32'd0, 32'h0,         32'd0, 32'd0, 32'h0,  32'd1, 32'h8},
      '{32'd0, 32'd0, 32'h0,         32'd1, 32'd0, 32'h0,  32'd1, 32'h8},
      '{32'd0, 32'd0, 32'h0,         32'd1, 32'd1, 32'h10, 32'd1, 32'hC},
      '{32'd0, 32'd0, 32'h0,         32'd1, 32'd1, 32'h10, 32'd0, 32'h0}
    };
    cyc = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      imem_req_ready = tv[i].rr[0]; imem_rsp_valid = tv[i].rv[0]; imem_rsp_data = tv[i].rdata;
      instr_ready = tv[i].ir[0]; redirect_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tv%0d_req_valid", i), 32'(imem_req_valid), tv[i].ev);
      if (tv[i].ev[0]) chk($sformatf("tv%0d_req_addr", i), imem_req_addr, tv[i].ea);
      chk($sformatf("tv%0d_instr_valid", i), 32'(instr_valid), tv[i].iv);
      chk($sformatf("tv%0d_instr_pc", i), instr_pc, tv[i].ipc);
      chk($sformatf("tv%0d_instr", i), instr, tv[i].iv[0] ? tv[i].ipc ^ KEY : 32'h0);
    end

    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("fill_req_stalled", 32'(imem_req_valid), 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_got("fill_order0", 0, 32'h0);
    expect_got("fill_order1", 1, 32'h4);
    expect_got("fill_order2", 2, 32'h8);

    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    got_q.delete();
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("flush_empty", 32'(instr_valid), 32'h0);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_got("redir_first", 0, 32'h100);
    expect_got("redir_second", 1, 32'h104);

    do_reset();
    lat_min = 1; lat_max = 2;
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    got_q.delete();
    step(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("misalign_flag", 32'(instr_misaligned), 32'(MIS));
    chk("misalign_req", 32'(imem_req_valid), 32'(!MIS));
`ifdef IFETCH_MISALIGN_EN
    chk("misalign_no_fetch", 32'(got_q.size()), 32'h0);
`else
    expect_got("misalign_resume", 0, 32'h100);
`endif
    got_q.delete();
    step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("aligned_clears_flag", 32'(instr_misaligned), 32'h0);
    expect_got("aligned_resume", 0, 32'h200);

    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_got("wrap0", 0, 32'hFFFF_FFF8);
    expect_got("wrap1", 1, 32'hFFFF_FFFC);
    expect_got("wrap2", 2, 32'h0000_0000);
    expect_got("wrap3", 3, 32'h0000_0004);

    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(15) == 0) rpc = 32'hFFFF_FFF0;
      step($urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(19) == 0, rpc, $urandom_range(4) == 0);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
